sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one synchronous single-port SRAM (1-cycle read latency) between the fetch
//  requester (inst side, driven by if_stage) and the load/store requester (data side,
//  driven by the EX/MEM stages). Grants one request per cycle and returns read data
//  one cycle after the grant. Keeps a response-owner pipeline and an anti-starvation
//  counter, so fetch still progresses under back-to-back memory traffic.
// PARAMETERS
//  ADDR_W      32  address width, both requesters and the SRAM
//  DATA_W      32  data width; DATA_W/8 byte strobes
//  STARVE_MAX  4   consecutive denied inst cycles before inst is forced through (>=1)
// PORTS
//  clk          in   1         clock, all state on rising edge
//  resetn       in   1         asynchronous, active-low reset
//  i_req        in   1         inst request (read only)
//  i_addr       in   ADDR_W    inst address
//  i_addr_ok    out  1         inst request granted this cycle
//  i_data_ok    out  1         inst read data valid this cycle
//  i_rdata      out  DATA_W    inst read data
//  d_req        in   1         data request
//  d_wr         in   1         1 = store, 0 = load
//  d_wstrb      in   DATA_W/8  store byte enables
//  d_addr       in   ADDR_W    data address
//  d_wdata      in   DATA_W    store data
//  d_addr_ok    out  1         data request granted this cycle
//  d_data_ok    out  1         load data valid / store complete this cycle
//  d_rdata      out  DATA_W    load data
//  sram_en      out  1         SRAM access enable
//  sram_we      out  DATA_W/8  SRAM byte write enables
//  sram_addr    out  ADDR_W    SRAM address
//  sram_wdata   out  DATA_W    SRAM write data
//  sram_rdata   in   DATA_W    SRAM read data, valid the cycle after sram_en
// BEHAVIOUR
//  - Grant is combinational in cycle t: at most one of i_addr_ok/d_addr_ok is high;
//    a requester's addr_ok is never high unless its req is high.
//  - On grant: sram_en=1; sram_addr/sram_wdata muxed from the winner;
//    sram_we = d_wr ? d_wstrb : 0 (always 0 for inst). No grant: sram_en=0, sram_we=0.
//  - Response: registered owner {resp_vld, resp_id}; at t+1 the owner's data_ok=1 and
//    its rdata=sram_rdata. The other side's data_ok=0, and its rdata holds 0.
//    Stores also get d_data_ok at t+1.
//  - Throughput: one grant per cycle; a grant at t+1 overlaps the response of t.
//    No backpressure; requesters must accept data_ok when it pulses.
//  - Priority (default): data beats inst when both request, except when
//    starve_cnt==STARVE_MAX, when inst wins.
//  - starve_cnt: +1 each cycle i_req=1 and inst not granted, saturating at STARVE_MAX;
//    cleared to 0 when inst granted or i_req=0.
//  - Requests are not queued: a denied requester keeps req/addr stable and retries.
//  - Reset (async, any time): resp_vld=0, starve_cnt=0, rr_last=0. All outputs go to 0
//    while resetn=0, including any pending data_ok, which is dropped.
//  - First grant possible in the first cycle after resetn deasserts.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin replaces fixed priority.
//   - 1-bit rr_last (0=inst, 1=data) records the last winner.
//   - On conflict the side not equal to rr_last wins; rr_last updates on every grant.
//   - starve_cnt logic and STARVE_MAX are compiled out.
//  ARB_RR_EN undefined: fixed data priority plus starvation counter, as above.
// TESTING
//  1 Reset: resetn=0 mid-response, i_req=1 -> all outputs 0; no data_ok after release.
//  2 Inst only: i_req=1, i_addr=0x1c000000 -> i_addr_ok=1, sram_en=1, sram_we=0 at t;
//    i_data_ok=1, i_rdata=sram_rdata at t+1.
//  3 Store then load, back to back: d_wr=1, d_wstrb=4'b0011, d_addr=0x100, d_wdata=0xA5A5_5A5A
//    -> sram_we=4'b0011; next cycle a load to 0x100 -> d_data_ok on both t+1 and t+2.
//  4 Conflict, default build: i_req=d_req=1 held, STARVE_MAX=4 -> data granted 4 cycles,
//    inst granted on the 5th, then data again.
//  5 Conflict with ARB_RR_EN: both held -> grants alternate inst/data/inst/data.
//    Exactly one addr_ok per cycle.
//  6 Overlap: inst granted at t, data granted at t+1 -> i_data_ok at t+1, d_data_ok at t+2.
//    rdata is routed to the correct side.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one synchronous single-port SRAM (1-cycle read latency) between the
//   instruction fetch requester and the load/store requester. One grant per
//   cycle. Read data (or store completion) is returned to the granted side one
//   cycle later, tracked by a small response-owner register.
//
//   Configuration macro: ARB_RR_EN
//     undefined : data side has fixed priority; a starvation counter forces
//                 the inst side through after STARVE_MAX denied cycles.
//     defined   : round-robin on conflict using a 1-bit last-winner flag;
//                 the starvation counter is compiled out.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  // instruction side (read only)
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  // data side
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  // SRAM port
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int STRB_W = DATA_W / 8;

  // Who the response arriving next cycle belongs to.
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  logic   grant_i_s;
  logic   grant_d_s;
  logic   resp_vld_r;
  owner_e resp_id_r;

`ifdef ARB_RR_EN
  // 0 = inst won last, 1 = data won last
  logic rr_last_r;
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] starve_cnt_r;
`endif

  // Pick at most one winner this cycle; nothing is granted while in reset.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (!resetn) begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end else if (i_req && d_req) begin
`ifdef ARB_RR_EN
      // On conflict the side that did not win last time goes first.
      if (rr_last_r) begin
        grant_i_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
`else
      // Data has priority unless inst has been starved long enough.
      if (starve_cnt_r == CNT_MAX) begin
        grant_i_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
`endif
    end else if (i_req) begin
      grant_i_s = 1'b1;
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Drive the SRAM request from the winner; idle port when nothing is granted.
  always_comb begin
    sram_en    = grant_i_s | grant_d_s;
    sram_we    = {STRB_W{1'b0}};
    sram_addr  = {ADDR_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    if (grant_d_s) begin
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
      if (d_wr) begin
        sram_we = d_wstrb;
      end else begin
        sram_we = {STRB_W{1'b0}};
      end
    end else if (grant_i_s) begin
      sram_addr = i_addr;
    end else begin
      sram_addr = {ADDR_W{1'b0}};
    end
  end

  assign i_addr_ok = grant_i_s;
  assign d_addr_ok = grant_d_s;

  // Route the one-cycle-late SRAM response to the side that owns it.
  always_comb begin
    i_data_ok = 1'b0;
    d_data_ok = 1'b0;
    i_rdata   = {DATA_W{1'b0}};
    d_rdata   = {DATA_W{1'b0}};
    if (resp_vld_r) begin
      case (resp_id_r)
        OWN_INST: begin
          i_data_ok = 1'b1;
          i_rdata   = sram_rdata;
        end
        OWN_DATA: begin
          d_data_ok = 1'b1;
          d_rdata   = sram_rdata;
        end
        default: begin
          i_data_ok = 1'b0;
          d_data_ok = 1'b0;
        end
      endcase
    end else begin
      i_data_ok = 1'b0;
      d_data_ok = 1'b0;
    end
  end

  // Remember which side was granted so its data_ok fires next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_vld_r <= 1'b0;
      resp_id_r  <= OWN_INST;
    end else begin
      resp_vld_r <= grant_i_s | grant_d_s;
      resp_id_r  <= grant_d_s ? OWN_DATA : OWN_INST;
    end
  end

`ifdef ARB_RR_EN
  // Track the last winner for round-robin; hold when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last_r <= 1'b0;
    end else if (grant_i_s) begin
      rr_last_r <= 1'b0;
    end else if (grant_d_s) begin
      rr_last_r <= 1'b1;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end
`else
  // Count consecutive cycles inst is waiting; saturate, clear on grant or no request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (i_req && !grant_i_s) begin
      if (starve_cnt_r == CNT_MAX) begin
        starve_cnt_r <= starve_cnt_r;
      end else begin
        starve_cnt_r <= starve_cnt_r + CNT_ONE;
      end
    end else begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed and randomized stimulus for sram_port_arbiter, checked against a
//   cycle-level reference model of the arbitration rules kept in this bench.
//   Honours ARB_RR_EN the same way as the design.
module tb_sram_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              resetn;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_wr;
  logic [3:0]        d_wstrb;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [31:0]       d_rdata;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [31:0]       sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_pend_vld;
  bit m_pend_data;
  int m_wait;
  bit m_rr_last;
  bit gi;
  bit gd;
  logic [9:0] hist;

  sram_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_wr(d_wr),
    .d_wstrb(d_wstrb),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok),
    .d_rdata(d_rdata),
    .sram_en(sram_en),
    .sram_we(sram_we),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs were set just after a falling edge by the caller.
  task automatic run_cycle();
    bit          exp_iok;
    bit          exp_dok;
    logic [31:0] exp_addr;
    sram_rdata = $urandom;
    #1;
    if (!resetn) begin
      m_pend_vld  = 1'b0;
      m_pend_data = 1'b0;
      m_wait      = 0;
      m_rr_last   = 1'b0;
    end
    gi = 1'b0;
    gd = 1'b0;
    if (resetn) begin
      if (i_req && d_req) begin
`ifdef ARB_RR_EN
        gi = m_rr_last;
`else
        gi = (m_wait >= STARVE_MAX);
`endif
        gd = !gi;
      end else begin
        gi = i_req;
        gd = d_req;
      end
    end
    exp_iok  = m_pend_vld && !m_pend_data;
    exp_dok  = m_pend_vld && m_pend_data;
    exp_addr = gd ? d_addr : (gi ? i_addr : 32'h0000_0000);
    chk("i_addr_ok", i_addr_ok, gi);
    chk("d_addr_ok", d_addr_ok, gd);
    chk("sram_en", sram_en, gi || gd);
    chk("sram_we", sram_we, (gd && d_wr) ? d_wstrb : 4'b0000);
    if (gi || gd || !resetn) chk("sram_addr", sram_addr, exp_addr);
    if (gd || !resetn) chk("sram_wdata", sram_wdata, gd ? d_wdata : 32'h0000_0000);
    chk("i_data_ok", i_data_ok, exp_iok);
    chk("d_data_ok", d_data_ok, exp_dok);
    chk("i_rdata", i_rdata, exp_iok ? sram_rdata : 32'h0000_0000);
    chk("d_rdata", d_rdata, exp_dok ? sram_rdata : 32'h0000_0000);
    @(posedge clk);
    if (!resetn) begin
      m_pend_vld = 1'b0;
      m_wait     = 0;
    end else begin
      m_pend_vld  = gi || gd;
      m_pend_data = gd;
      if (gi) m_rr_last = 1'b0;
      else if (gd) m_rr_last = 1'b1;
      if (i_req && !gi) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
      else m_wait = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req   = 1'b0;
    i_addr  = 32'h0000_0000;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_wstrb = 4'b0000;
    d_addr  = 32'h0000_0000;
    d_wdata = 32'h0000_0000;
  endtask

  initial begin
    logic [9:0] exp_hist;
    idle_inputs();
    resetn     = 1'b0;
    sram_rdata = 32'h0000_0000;
    hist       = 10'b0;
    m_pend_vld = 1'b0; m_pend_data = 1'b0; m_wait = 0; m_rr_last = 1'b0;
    @(negedge clk);
    run_cycle();
    run_cycle();

    // Inst only, first cycle out of reset, then held in reset mid-response.
    resetn = 1'b1;
    i_req  = 1'b1;
    i_addr = 32'h1c00_0000;
    run_cycle();
    resetn = 1'b0;
    run_cycle();
    run_cycle();
    resetn = 1'b1;
    i_req  = 1'b0;
    run_cycle();
    chk("no_data_ok_after_reset", {i_data_ok, d_data_ok}, 2'b00);

    // Inst only, plain read with response next cycle.
    i_req  = 1'b1;
    i_addr = 32'h1c00_0004;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Store then load back to back, then idle to see the load data.
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_wstrb = 4'b0011;
    d_addr  = 32'h0000_0100;
    d_wdata = 32'hA5A5_5A5A;
    run_cycle();
    d_wr    = 1'b0;
    d_wstrb = 4'b1111;
    run_cycle();
    idle_inputs();
    run_cycle();
    run_cycle();

    // Overlap: inst at t, data at t+1.
    i_req  = 1'b1;
    i_addr = 32'h1c00_0040;
    run_cycle();
    idle_inputs();
    d_req  = 1'b1;
    d_addr = 32'h0000_0200;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Conflict held from a fresh reset: record which side wins each cycle.
    resetn = 1'b0;
    run_cycle();
    resetn = 1'b1;
    i_req  = 1'b1;
    i_addr = 32'h1c00_0080;
    d_req  = 1'b1;
    d_addr = 32'h0000_0300;
    for (int k = 0; k < 10; k++) begin
      #1;
      hist[k] = i_addr_ok;
      run_cycle();
    end
`ifdef ARB_RR_EN
    exp_hist = 10'b10_1010_1010;
`else
    exp_hist = 10'b10_0001_0000;
`endif
    chk("conflict_pattern", hist, exp_hist);
    idle_inputs();
    run_cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      i_req   = ($urandom_range(0, 3) != 0);
      i_addr  = $urandom;
      d_req   = ($urandom_range(0, 2) != 0);
      d_wr    = $urandom_range(0, 1);
      d_wstrb = 4'($urandom_range(0, 15));
      d_addr  = $urandom;
      d_wdata = $urandom;
      run_cycle();
    end
    idle_inputs();
    run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
